// File: rtl/af_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// af_sweep_ctrl
//
// Autofocus sequencer. It steps the VCM lens through a coarse sweep of the
// full code range, then a fine sweep around the best coarse position, and
// finally parks the lens on the sharpest position seen in either sweep.
// Every lens code goes to the VCM I2C writer through a STEP_REQ/STEP_ACK
// handshake. After each ack a few frames are skipped so the lens can settle,
// and then the sharpness of the next frame is sampled.
//
// Ports:
//   CLK         system clock
//   RESET_n     asynchronous active-low reset
//   START       one-cycle pulse, starts a sweep when idle
//   VS          one-cycle end-of-frame strobe, SHARP valid with it
//   SHARP       sharpness metric of the frame that just ended
//   STEP_ACK    one-cycle pulse, VCM writer has written STEP
//   STEP        lens code presented to the VCM writer
//   STEP_REQ    request to write STEP
//   BUSY        high from accepted START until DONE
//   DONE        one-cycle pulse once the final position is acked
//   BEST_STEP   lens code of the sharpest frame so far
//   BEST_SHARP  sharpness value at BEST_STEP
// ---------------------------------------------------------------------------
module af_sweep_ctrl #(
    parameter int unsigned C_STEP    = 48,
    parameter int unsigned F_STEP    = 4,
    parameter int unsigned F_SPAN    = 48,
    parameter int unsigned SETTLE_FR = 2,
    parameter int unsigned STEP_MAX  = 1023
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        START,
    input  logic        VS,
    input  logic [23:0] SHARP,
    input  logic        STEP_ACK,
    output logic [9:0]  STEP,
    output logic        STEP_REQ,
    output logic        BUSY,
    output logic        DONE,
    output logic [9:0]  BEST_STEP,
    output logic [23:0] BEST_SHARP
);

    // Position arithmetic is done in 11 bits so that pos + increment can
    // exceed STEP_MAX without wrapping.
    localparam logic [10:0] CSTEP11  = 11'(C_STEP);
    localparam logic [10:0] FSTEP11  = 11'(F_STEP);
    localparam logic [10:0] FSPAN11  = 11'(F_SPAN);
    localparam logic [10:0] SMAX11   = 11'(STEP_MAX);
    localparam logic [3:0]  SETTLE4  = 4'(SETTLE_FR);

    typedef enum logic [3:0] {
        IDLE,
        SET,
        ACKW,
        SETTLE,
        MEAS,
        NEXT,
        FSET,
        FACK,
        FIN
    } state_e;

    state_e      state_q;
    logic [10:0] pos_q;
    logic [10:0] hi_q;
    logic        fine_q;
    logic [3:0]  frameCnt_q;
    logic [9:0]  step_q;
    logic        req_q;
    logic        busy_q;
    logic        done_q;
    logic [9:0]  bestStep_q;
    logic [23:0] bestSharp_q;

    logic [10:0] nxt_d;
    logic [10:0] lo_d;
    logic [10:0] hi_d;
    logic [10:0] hiSum_d;
    logic [3:0]  frameCnt_d;

    // Candidate next position and the fine-sweep window around the current
    // best code. The low bound is clamped at 0 by comparing before
    // subtracting, so a peak near code 0 never wraps.
    always_comb begin
        nxt_d      = pos_q + (fine_q ? FSTEP11 : CSTEP11);
        lo_d       = ({1'b0, bestStep_q} < FSPAN11) ? 11'd0
                                                    : ({1'b0, bestStep_q} - FSPAN11);
        hiSum_d    = {1'b0, bestStep_q} + FSPAN11;
        hi_d       = (hiSum_d > SMAX11) ? SMAX11 : hiSum_d;
        frameCnt_d = frameCnt_q + 4'd1;
    end

    // Sequencer. All outputs are registered here; reset aborts any sweep
    // and drops STEP_REQ without waiting for an ack.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q     <= IDLE;
            pos_q       <= '0;
            hi_q        <= '0;
            fine_q      <= 1'b0;
            frameCnt_q  <= '0;
            step_q      <= '0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bestStep_q  <= '0;
            bestSharp_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (START) begin
                        pos_q       <= '0;
                        bestSharp_q <= '0;
                        bestStep_q  <= '0;
                        fine_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= SET;
                    end
                end
                SET: begin
                    step_q  <= pos_q[9:0];
                    req_q   <= 1'b1;
                    state_q <= ACKW;
                end
                ACKW: begin
                    if (STEP_ACK) begin
                        req_q      <= 1'b0;
                        frameCnt_q <= '0;
                        state_q    <= SETTLE;
                    end
                end
                SETTLE: begin
                    // A VS in the ack cycle was seen in ACKW, so it never
                    // reaches this counter.
                    if (SETTLE4 == 4'd0) begin
                        state_q <= MEAS;
                    end else if (VS) begin
                        frameCnt_q <= frameCnt_d;
                        if (frameCnt_d == SETTLE4) begin
                            state_q <= MEAS;
                        end
                    end
                end
                MEAS: begin
                    if (VS) begin
                        // Strictly greater: on a tie the earlier code wins.
                        if (SHARP > bestSharp_q) begin
                            bestSharp_q <= SHARP;
                            bestStep_q  <= pos_q[9:0];
                        end
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    if (!fine_q) begin
                        if (nxt_d > SMAX11) begin
                            pos_q  <= lo_d;
                            hi_q   <= hi_d;
                            fine_q <= 1'b1;
                        end else begin
                            pos_q <= nxt_d;
                        end
                        state_q <= SET;
                    end else if (nxt_d > hi_q) begin
                        state_q <= FSET;
                    end else begin
                        pos_q   <= nxt_d;
                        state_q <= SET;
                    end
                end
                FSET: begin
                    step_q  <= bestStep_q;
                    req_q   <= 1'b1;
                    state_q <= FACK;
                end
                FACK: begin
                    if (STEP_ACK) begin
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign STEP       = step_q;
    assign STEP_REQ   = req_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign BEST_STEP  = bestStep_q;
    assign BEST_SHARP = bestSharp_q;

endmodule

// File: tb/tb_af_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_af_sweep_ctrl
//
// Self-checking bench for af_sweep_ctrl. The environment acts as the VCM
// writer (acks each request after a delay) and as the frame source (VS with
// random frame lengths). Each lens code has an entry in a sharpness table.
// SHARP carries the table value of the last acked code only on the frame
// that should be measured. Every other frame carries a decoy value larger
// than any table value, so sampling the wrong frame corrupts BEST_SHARP.
// The expected request sequence and peak come from a list-based sweep model.
// ---------------------------------------------------------------------------
module tb_af_sweep_ctrl;

    localparam int          SETTLE = 2;
    localparam logic [23:0] DECOY  = 24'hFFFFFF;

    logic        CLK = 1'b0;
    logic        RESET_n = 1'b0;
    logic        START = 1'b0;
    logic        VS = 1'b0;
    logic [23:0] SHARP = '0;
    logic        STEP_ACK = 1'b0;
    logic [9:0]  STEP;
    logic        STEP_REQ;
    logic        BUSY;
    logic        DONE;
    logic [9:0]  BEST_STEP;
    logic [23:0] BEST_SHARP;

    logic [23:0] sharpTable [1024];
    int          reqLog [$];
    int          expLog [$];
    int          expBestStep;
    int          expBestSharp;

    int          checkCount = 0;
    int          passCount = 0;

    int          ackDelayFixed = 0;
    bit          forceVsOnAck = 1'b0;
    bit          ackPending = 1'b0;
    int          ackCountdown = 0;
    logic [9:0]  pendingCode = '0;
    int          ackedCode = 0;
    int          vsAfterAck = 100;
    int          frameTimer = 5;

    af_sweep_ctrl #(
        .C_STEP    (48),
        .F_STEP    (4),
        .F_SPAN    (48),
        .SETTLE_FR (SETTLE),
        .STEP_MAX  (1023)
    ) u_dut (
        .CLK        (CLK),
        .RESET_n    (RESET_n),
        .START      (START),
        .VS         (VS),
        .SHARP      (SHARP),
        .STEP_ACK   (STEP_ACK),
        .STEP       (STEP),
        .STEP_REQ   (STEP_REQ),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .BEST_STEP  (BEST_STEP),
        .BEST_SHARP (BEST_SHARP)
    );

    always #5 CLK = ~CLK;

    // Single comparison point: counts the check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Sweep model: coarse list over the whole range, best by strict '>',
    // fine list over the clamped window, then the park position.
    task automatic modelSweep();
        int bs;
        int bk;
        int lo;
        int hi;
        expLog.delete();
        bs = 0;
        bk = 0;
        for (int c = 0; c <= 1023; c += 48) begin
            expLog.push_back(c);
            if (int'(sharpTable[c]) > bs) begin
                bs = int'(sharpTable[c]);
                bk = c;
            end
        end
        lo = (bk - 48 < 0) ? 0 : bk - 48;
        hi = (bk + 48 > 1023) ? 1023 : bk + 48;
        for (int f = lo; f <= hi; f += 4) begin
            expLog.push_back(f);
            if (int'(sharpTable[f]) > bs) begin
                bs = int'(sharpTable[f]);
                bk = f;
            end
        end
        expLog.push_back(bk);
        expBestStep  = bk;
        expBestSharp = bs;
    endtask

    // Single-peaked sharpness curve with optional noise.
    task automatic setPeak(input int peak, input int noise);
        int d;
        for (int c = 0; c < 1024; c++) begin
            d = (c > peak) ? c - peak : peak - c;
            sharpTable[c] = 24'(200000 - d * 100 + ((noise > 0) ? int'($urandom_range(0, noise)) : 0));
        end
    endtask

    // VCM writer and frame source, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (STEP_ACK) begin
                ackedCode  = int'(pendingCode);
                vsAfterAck = 0;
            end else if (VS) begin
                vsAfterAck++;
            end
            STEP_ACK = 1'b0;
            VS       = 1'b0;
            if (!RESET_n) begin
                ackPending = 1'b0;
            end else if (ackPending) begin
                ackCountdown--;
                if (ackCountdown == 0) begin
                    checkOutput("reqHeld", {STEP_REQ, STEP}, {1'b1, pendingCode});
                    STEP_ACK   = 1'b1;
                    ackPending = 1'b0;
                end
            end else if (STEP_REQ) begin
                pendingCode = STEP;
                reqLog.push_back(int'(STEP));
                ackPending   = 1'b1;
                ackCountdown = (ackDelayFixed > 0) ? ackDelayFixed
                                                   : int'($urandom_range(1, 4));
            end
            frameTimer--;
            if (frameTimer <= 0 || (forceVsOnAck && STEP_ACK)) begin
                VS         = 1'b1;
                frameTimer = int'($urandom_range(4, 8));
            end
            SHARP = (VS && !STEP_ACK && vsAfterAck == SETTLE) ? sharpTable[ackedCode] : DECOY;
        end
    end

    // Run one sweep to DONE and compare it against the model. expCount and
    // expBest are directed cross-checks (-1 skips them).
    task automatic applyStimulus(input string name, input bit pokeStart,
                                 input int expCount, input int expBest);
        int  cycles;
        bit  doneSeen;
        int  n;
        modelSweep();
        reqLog.delete();
        @(posedge CLK);
        #1 START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        @(negedge CLK);
        checkOutput({name, ".busy"}, 32'(BUSY), 32'd1);
        cycles   = 0;
        doneSeen = 1'b0;
        while (!doneSeen && cycles < 20000) begin
            @(negedge CLK);
            cycles++;
            if (DONE) begin
                doneSeen = 1'b1;
            end
            START = (pokeStart && (cycles % 300 == 150)) ? 1'b1 : 1'b0;
        end
        START = 1'b0;
        checkOutput({name, ".done"}, 32'(doneSeen), 32'd1);
        checkOutput({name, ".busyAtDone"}, 32'(BUSY), 32'd0);
        checkOutput({name, ".bestStep"}, 32'(BEST_STEP), 32'(expBestStep));
        checkOutput({name, ".bestSharp"}, 32'(BEST_SHARP), 32'(expBestSharp));
        checkOutput({name, ".parkStep"}, 32'(STEP), 32'(expBestStep));
        checkOutput({name, ".reqCount"}, 32'(reqLog.size()), 32'(expLog.size()));
        if (expCount >= 0) begin
            checkOutput({name, ".reqCountDirected"}, 32'(reqLog.size()), 32'(expCount));
        end
        if (expBest >= 0) begin
            checkOutput({name, ".bestDirected"}, 32'(BEST_STEP), 32'(expBest));
        end
        n = (reqLog.size() < expLog.size()) ? reqLog.size() : expLog.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s.req%0d", name, i), 32'(reqLog[i]), 32'(expLog[i]));
        end
        @(negedge CLK);
        checkOutput({name, ".donePulse"}, 32'(DONE), 32'd0);
        repeat (5) @(negedge CLK);
        checkOutput({name, ".holdStep"}, 32'(STEP), 32'(expBestStep));
        checkOutput({name, ".holdBest"}, 32'(BEST_SHARP), 32'(expBestSharp));
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, ".STEP"}, 32'(STEP), 32'd0);
        checkOutput({name, ".STEP_REQ"}, 32'(STEP_REQ), 32'd0);
        checkOutput({name, ".BUSY"}, 32'(BUSY), 32'd0);
        checkOutput({name, ".DONE"}, 32'(DONE), 32'd0);
        checkOutput({name, ".BEST_STEP"}, 32'(BEST_STEP), 32'd0);
        checkOutput({name, ".BEST_SHARP"}, 32'(BEST_SHARP), 32'd0);
    endtask

    initial begin
        int waitCycles;
        for (int c = 0; c < 1024; c++) begin
            sharpTable[c] = '0;
        end
        RESET_n = 1'b0;
        repeat (3) @(negedge CLK);
        checkAllZero("reset");
        @(posedge CLK);
        #1 RESET_n = 1'b1;
        repeat (3) @(posedge CLK);

        // Peak at 480 with a fixed ack latency of 3 cycles.
        ackDelayFixed = 3;
        setPeak(480, 0);
        applyStimulus("peak480", 1'b0, 48, 480);
        ackDelayFixed = 0;

        // Peak at the bottom edge: fine window clamps at 0.
        setPeak(0, 0);
        applyStimulus("peak0", 1'b0, 36, 0);

        // Peak at the last coarse point: fine window clamps at 1023.
        setPeak(1008, 0);
        applyStimulus("peak1008", 1'b0, 39, 1008);

        // Flat sharpness: ties keep the earliest code.
        for (int c = 0; c < 1024; c++) begin
            sharpTable[c] = 24'd100;
        end
        applyStimulus("flat", 1'b0, 36, 0);

        // Every ack carries a decoy VS, which must not count as a settle frame.
        forceVsOnAck = 1'b1;
        setPeak(int'($urandom_range(0, 1023)), 50);
        applyStimulus("vsOnAck", 1'b0, -1, -1);
        forceVsOnAck = 1'b0;

        // START pulses during the sweep are ignored.
        setPeak(int'($urandom_range(0, 1023)), 50);
        applyStimulus("midStart", 1'b1, -1, -1);

        // Reset in ACKW mid-sweep clears every output at once.
        setPeak(700, 0);
        reqLog.delete();
        @(posedge CLK);
        #1 START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        waitCycles = 0;
        while (!(reqLog.size() >= 5 && STEP_REQ) && waitCycles < 2000) begin
            @(negedge CLK);
            waitCycles++;
        end
        checkOutput("abort.reachedAckw", 32'(STEP_REQ), 32'd1);
        #2 RESET_n = 1'b0;
        #1;
        checkAllZero("abort");
        repeat (3) @(posedge CLK);
        #1 RESET_n = 1'b1;
        repeat (10) @(posedge CLK);
        applyStimulus("afterAbort", 1'b0, -1, 700);

        // Random peaks, noise, and one fully random table.
        for (int k = 0; k < 2; k++) begin
            setPeak(int'($urandom_range(0, 1023)), 300);
            applyStimulus($sformatf("rand%0d", k), 1'b0, -1, -1);
        end
        for (int c = 0; c < 1024; c++) begin
            sharpTable[c] = 24'($urandom_range(0, 1 << 20));
        end
        applyStimulus("randTable", 1'b0, -1, -1);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
